// File: rtl/montgomery_exp.sv
// Left-to-right square-and-multiply modular exponentiation controller driving an
// external start/done Montgomery multiplier; every product gets one conditional -M.
module montgomery_exp #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [EXP_WIDTH-1:0] in_e,
  input  logic [WIDTH-1:0]     in_m,
  input  logic [WIDTH-1:0]     in_r,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 mul_start,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic [WIDTH-1:0]     mul_m,
  input  logic [WIDTH:0]       mul_result,
  input  logic                 mul_done,
  output logic [2:0]           fsm_state
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    SQ_ISSUE  = 3'd2,
    SQ_WAIT   = 3'd3,
    MUL_ISSUE = 3'd4,
    MUL_WAIT  = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t               state, state_d;
  logic [WIDTH-1:0]     x_q, m_q, r_q;
  logic [EXP_WIDTH-1:0] e_q;
  logic [WIDTH-1:0]     acc, acc_d;
  logic [IW-1:0]        idx, idx_d;
  logic                 mul_done_q;
  logic                 load;
  logic                 issue;
  logic                 issue_mul;
  logic                 finish;
  logic                 mul_ack;
  logic                 bit_i;
  logic                 last;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     red_val;

  assign fsm_state = state;

  // Rising edge of mul_done only: a level-held done is one completion, and the
  // pulse cycle itself is never taken as a completion.
  assign mul_ack = mul_done & ~mul_done_q & ~mul_start;

  assign bit_i = e_q[idx];
  assign last  = (idx == '0);

  // Lower WIDTH bits of p - M equal the truncated (WIDTH+1)-bit difference.
  assign diff    = mul_result[WIDTH-1:0] - m_q;
  assign red_val = (mul_result >= {1'b0, m_q}) ? diff : mul_result[WIDTH-1:0];

  always_comb begin
    state_d   = state;
    acc_d     = acc;
    idx_d     = idx;
    load      = 1'b0;
    issue     = 1'b0;
    issue_mul = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          idx_d   = IW'(EXP_WIDTH - 1);
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bit_i) begin
          acc_d = x_q;
          if (last) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx - 1'b1;
            state_d = SQ_ISSUE;
          end
        end else if (last) begin
          acc_d   = r_q;
          state_d = FINISH;
        end else begin
          idx_d = idx - 1'b1;
        end
      end
      SQ_ISSUE: begin
        issue   = 1'b1;
        state_d = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mul_ack) begin
          acc_d = red_val;
          if (bit_i) begin
            state_d = MUL_ISSUE;
          end else if (last) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx - 1'b1;
            state_d = SQ_ISSUE;
          end
        end
      end
      MUL_ISSUE: begin
        issue     = 1'b1;
        issue_mul = 1'b1;
        state_d   = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_ack) begin
          acc_d = red_val;
          if (last) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx - 1'b1;
            state_d = SQ_ISSUE;
          end
        end
      end
      FINISH: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      x_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      r_q        <= '0;
      acc        <= '0;
      idx        <= '0;
      mul_done_q <= 1'b0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_m      <= '0;
      result     <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      acc        <= acc_d;
      idx        <= idx_d;
      mul_done_q <= mul_done;
      mul_start  <= issue;
      done       <= finish;
      if (load) begin
        x_q <= in_x;
        e_q <= in_e;
        m_q <= in_m;
        r_q <= in_r;
      end
      // Operands only change when a new operation is issued, so they stay
      // stable through the wait and the cycle after completion.
      if (issue) begin
        mul_a <= acc;
        mul_b <= issue_mul ? x_q : acc;
        mul_m <= m_q;
      end
      if (finish) begin
        result <= acc;
      end
    end
  end

endmodule

// File: tb/tb_montgomery_exp.sv
// Directed bench for montgomery_exp with an adder stub standing in for the
// multiplier, so the exponent result reduces to (e * X) mod M.
module tb_montgomery_exp;

  localparam int W  = 16;
  localparam int EW = 8;
  localparam logic [W-1:0] MOD = 16'hFFF1;
  localparam logic [2:0] ST_SQ_WAIT  = 3'd3;
  localparam logic [2:0] ST_MUL_WAIT = 3'd5;

  logic          clk;
  logic          resetn;
  logic          start;
  logic [W-1:0]  in_x, in_m, in_r;
  logic [EW-1:0] in_e;
  logic [W-1:0]  result;
  logic          done;
  logic          mul_start;
  logic [W-1:0]  mul_a, mul_b, mul_m;
  logic [W:0]    mul_result;
  logic          mul_done;
  logic [2:0]    fsm_state;

  montgomery_exp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_x       (in_x),
    .in_e       (in_e),
    .in_m       (in_m),
    .in_r       (in_r),
    .result     (result),
    .done       (done),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_m      (mul_m),
    .mul_result (mul_result),
    .mul_done   (mul_done),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // multiplier stub: returns mul_a + mul_b five cycles after mul_start
  int          hold_cycles = 1;
  logic        force_en = 1'b0;
  logic [W:0]  force_val = '0;
  logic        busy;
  int          cnt;
  int          hold;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy       <= 1'b0;
      cnt        <= 0;
      hold       <= 0;
      mul_done   <= 1'b0;
      mul_result <= '0;
    end else begin
      if (mul_start) begin
        busy       <= 1'b1;
        cnt        <= 3;
        mul_result <= force_en ? force_val : ({1'b0, mul_a} + {1'b0, mul_b});
      end else if (busy) begin
        if (cnt > 0) begin
          cnt <= cnt - 1;
        end else begin
          busy     <= 1'b0;
          mul_done <= 1'b1;
          hold     <= hold_cycles - 1;
        end
      end
      if (!busy && mul_done) begin
        if (hold > 0) hold <= hold - 1;
        else mul_done <= 1'b0;
      end
    end
  end

  // scoreboard and protocol monitor
  logic [W-1:0] exp_q[$];
  int           mul_cnt = 0;
  int           stab_err = 0;
  int           done_cyc = 0;
  logic         done_prev = 1'b0;
  logic [W-1:0] cap_a = '0, cap_b = '0;
  logic [W-1:0] exp_v;

  always @(negedge clk) begin
    if (resetn) begin
      if (mul_start) begin
        mul_cnt++;
        cap_a = mul_a;
        cap_b = mul_b;
        checks++;
        assert (busy === 1'b0) else begin
          errors++;
          $error("FAIL mul_start_overlap: got busy=%0b required busy=0", busy);
        end
      end else if (busy || mul_done) begin
        if (mul_a !== cap_a || mul_b !== cap_b) stab_err++;
      end
    end
    if (done) begin
      done_cyc = cyc;
      checks++;
      assert (done_prev === 1'b0) else begin
        errors++;
        $error("FAIL done_pulse: got done high %0d cycles, required 1", 2);
      end
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_done: got done with %0d pending, required >0", exp_q.size());
      end
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        checks++;
        assert (result === exp_v) else begin
          errors++;
          $error("FAIL result: got %h required %h", result, exp_v);
        end
      end
    end
    done_prev = done;
  end

  function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic [EW-1:0] e,
                                         input logic [W-1:0] r);
    longint unsigned p;
    if (e == '0) return r;
    p = (longint'(e) * longint'(x)) % longint'(MOD);
    return p[W-1:0];
  endfunction

  function automatic int ops_for(input logic [EW-1:0] e);
    int bl = 0;
    int pc = 0;
    if (e == '0) return 0;
    for (int i = 0; i < EW; i++) begin
      if (e[i]) begin
        pc++;
        bl = i + 1;
      end
    end
    return (bl - 1) + (pc - 1);
  endfunction

  // driver: one exponentiation, optional latency check and mid-op start poke
  task automatic run(input logic [W-1:0] x, input logic [EW-1:0] e, input logic [W-1:0] r,
                     input logic [W-1:0] expv, input int ops, input int hc,
                     input int lat, input bit poke);
    int start_cyc;
    hold_cycles = hc;
    in_x = x;
    in_e = e;
    in_m = MOD;
    in_r = r;
    exp_q.push_back(expv);
    mul_cnt  = 0;
    stab_err = 0;
    @(posedge clk);
    #1;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_x  = W'($urandom);
    in_e  = EW'($urandom);
    in_r  = W'($urandom);
    if (poke) begin
      for (int k = 0; k < 200 && fsm_state != ST_SQ_WAIT; k++) @(negedge clk);
      checks++;
      assert (fsm_state === ST_SQ_WAIT) else begin
        errors++;
        $error("FAIL reach_sq_wait: got state %0d required %0d", fsm_state, ST_SQ_WAIT);
      end
      @(posedge clk);
      #1;
      start = 1'b1;
      in_x  = 16'h0077;
      in_e  = 8'hFF;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL done_timeout: got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    checks++;
    assert (mul_cnt == ops) else begin
      errors++;
      $error("FAIL mul_count: got %0d required %0d", mul_cnt, ops);
    end
    checks++;
    assert (stab_err == 0) else begin
      errors++;
      $error("FAIL operand_stable: got %0d changes required 0", stab_err);
    end
    if (lat > 0) begin
      checks++;
      assert (done_cyc - start_cyc == lat) else begin
        errors++;
        $error("FAIL latency: got %0d required %0d", done_cyc - start_cyc, lat);
      end
    end
  endtask

  logic [W-1:0]  rx;
  logic [EW-1:0] re;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    in_x   = '0;
    in_e   = '0;
    in_m   = '0;
    in_r   = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (result === '0 && done === 1'b0) else begin
      errors++;
      $error("FAIL reset_result: got result=%h done=%b required 0/0", result, done);
    end
    checks++;
    assert (mul_start === 1'b0 && mul_a === '0 && mul_b === '0 && mul_m === '0) else begin
      errors++;
      $error("FAIL reset_mul: got start=%b a=%h b=%h m=%h required all 0",
             mul_start, mul_a, mul_b, mul_m);
    end
    @(negedge clk);
    resetn = 1'b1;

    run(16'h0005, 8'd13, 16'h000F, 16'h0041, 5, 1, 0, 1'b0);
    run(16'h1111, 8'd0, 16'h000F, 16'h000F, 0, 1, 10, 1'b0);
    run(16'h1234, 8'd1, 16'h000F, 16'h1234, 0, 1, 10, 1'b0);
    run(16'h8000, 8'd2, 16'h000F, 16'h000F, 1, 1, 0, 1'b0);

    force_en  = 1'b1;
    force_val = {1'b0, MOD};
    run(16'h0003, 8'd2, 16'h000F, 16'h0000, 1, 1, 0, 1'b0);
    force_en  = 1'b0;

    run(16'h0005, 8'd13, 16'h000F, 16'h0041, 5, 3, 0, 1'b1);
    run(16'hABCD, 8'hFF, 16'h000F, model(16'hABCD, 8'hFF, 16'h000F), ops_for(8'hFF), 3, 0, 1'b0);
    run(16'h7F01, 8'h80, 16'h000F, model(16'h7F01, 8'h80, 16'h000F), ops_for(8'h80), 1, 0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      rx = W'($urandom_range(0, int'(MOD) - 1));
      re = EW'($urandom_range(1, 255));
      run(rx, re, 16'h000F, model(rx, re, 16'h000F), ops_for(re), $urandom_range(1, 3), 0, 1'b0);
    end

    // reset in the middle of a multiply wait
    hold_cycles = 1;
    in_x = 16'h0005;
    in_e = 8'd13;
    in_m = MOD;
    in_r = 16'h000F;
    exp_q.push_back(16'h0041);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 300 && fsm_state != ST_MUL_WAIT; k++) @(negedge clk);
    checks++;
    assert (fsm_state === ST_MUL_WAIT) else begin
      errors++;
      $error("FAIL reach_mul_wait: got state %0d required %0d", fsm_state, ST_MUL_WAIT);
    end
    @(negedge clk);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    assert (result === '0 && done === 1'b0 && mul_start === 1'b0) else begin
      errors++;
      $error("FAIL async_reset_ctl: got result=%h done=%b start=%b required 0/0/0",
             result, done, mul_start);
    end
    checks++;
    assert (mul_a === '0 && mul_b === '0 && mul_m === '0) else begin
      errors++;
      $error("FAIL async_reset_ops: got a=%h b=%h m=%h required 0/0/0", mul_a, mul_b, mul_m);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    run(16'h0005, 8'd13, 16'h000F, 16'h0041, 5, 1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
